object_depth_gen: RTL

Sequential producer for the renderer's depth-priority selector. Holds up to three moving game objects, advances them toward the viewer once per video frame, retires objects that reach the viewer, and accepts new objects through a valid/ready handshake. Drives the three slot depths and coordinates in nearest-first order, so that slot 1 is always the highest-priority candidate downstream.

---
 rtl/object_depth_gen.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/object_depth_gen.sv
// Depth producer for up to three moving objects: per-frame advance, retire,
// spawn handshake and a three-stage compare-exchange sort (nearest in slot 1).
module object_depth_gen #(
    parameter logic [5:0] SPAWN_DEPTH = 6'd62,
    parameter logic [5:0] FAR_DEPTH   = 6'd63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       spawn_valid,
    output logic       spawn_ready,
    input  logic [8:0] spawn_x,
    input  logic [8:0] spawn_y,
    input  logic [2:0] spawn_speed,
    output logic [5:0] d1,
    output logic [5:0] d2,
    output logic [5:0] d3,
    output logic [8:0] xc1,
    output logic [8:0] xc2,
    output logic [8:0] xc3,
    output logic [8:0] yc1,
    output logic [8:0] yc2,
    output logic [8:0] yc3,
    output logic [2:0] active,
    output logic       busy,
    output logic       frame_miss
);

    typedef enum logic [2:0] {
        IDLE, UPDATE, SORT0, SORT1, SORT2
    } state_t;

    typedef struct packed {
        logic       act;
        logic [2:0] spd;
        logic [8:0] y;
        logic [8:0] x;
        logic [5:0] dep;
    } slot_t;

    localparam slot_t EMPTY = '{
        act: 1'b0, spd: 3'd0, y: 9'd0, x: 9'd0, dep: FAR_DEPTH
    };

    state_t state_q, state_d;
    slot_t  slot_q [3];
    slot_t  slot_d [3];
    logic   miss_q, miss_d;
    logic [2:0] act_vec;
    logic [1:0] free_idx;
    logic       accept;

    always_comb begin
        for (int i = 0; i < 3; i++) act_vec[i] = slot_q[i].act;
    end

    // Lowest-index empty slot; only used when at least one is free.
    always_comb begin
        free_idx = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (!slot_q[i].act) free_idx = i[1:0];
        end
    end

    assign accept = spawn_valid && spawn_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (frame_tick)  state_d = UPDATE;
                else if (accept) state_d = SORT0;
            end
            UPDATE:  state_d = SORT0;
            SORT0:   state_d = SORT1;
            SORT1:   state_d = SORT2;
            SORT2:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy        = (state_q != IDLE);
        spawn_ready = (state_q == IDLE) && (act_vec != 3'b111)
                      && !frame_tick;
    end

    // Slot datapath
    always_comb begin
        for (int i = 0; i < 3; i++) slot_d[i] = slot_q[i];
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    slot_d[free_idx].act = 1'b1;
                    slot_d[free_idx].dep = SPAWN_DEPTH;
                    slot_d[free_idx].x   = spawn_x;
                    slot_d[free_idx].y   = spawn_y;
                    slot_d[free_idx].spd = (spawn_speed == 3'd0)
                                           ? 3'd1 : spawn_speed;
                end
            end
            UPDATE: begin
                for (int i = 0; i < 3; i++) begin
                    if (slot_q[i].act) begin
                        if (slot_q[i].dep <= {3'd0, slot_q[i].spd})
                            slot_d[i] = EMPTY;
                        else
                            slot_d[i].dep = slot_q[i].dep
                                            - {3'd0, slot_q[i].spd};
                    end
                end
            end
            SORT0, SORT2: begin
                if (slot_q[0].dep > slot_q[1].dep) begin
                    slot_d[0] = slot_q[1];
                    slot_d[1] = slot_q[0];
                end
            end
            SORT1: begin
                if (slot_q[1].dep > slot_q[2].dep) begin
                    slot_d[1] = slot_q[2];
                    slot_d[2] = slot_q[1];
                end
            end
            default: ;
        endcase
    end

    assign miss_d = miss_q || (frame_tick && (state_q != IDLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) slot_q[i] <= EMPTY;
            miss_q <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) slot_q[i] <= slot_d[i];
            miss_q <= miss_d;
        end
    end

    assign d1  = slot_q[0].dep;
    assign d2  = slot_q[1].dep;
    assign d3  = slot_q[2].dep;
    assign xc1 = slot_q[0].x;
    assign xc2 = slot_q[1].x;
    assign xc3 = slot_q[2].x;
    assign yc1 = slot_q[0].y;
    assign yc2 = slot_q[1].y;
    assign yc3 = slot_q[2].y;
    assign active     = act_vec;
    assign frame_miss = miss_q;

endmodule
